// File: rtl/slave_port_pkg.sv
// Shared types and constants for the bit-serial slave port.
// SLAVE_PORT_SPLIT_EN adds the SPLIT state used by split-capable builds.
package slave_port_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    MEMW  = 3'd3,
    MEMR  = 3'd4,
`ifdef SLAVE_PORT_SPLIT_EN
    SPLIT = 3'd6,
`endif
    RDATA = 3'd5
  } state_t;

  function automatic int cnt_width(input int addr_w, input int data_w);
    int widest;
    widest = (addr_w > data_w) ? addr_w : data_w;
    return $clog2(widest + 1);
  endfunction

endpackage

// File: rtl/slave_port_if.sv
// Serial bus lane between the bus fabric/master and a slave port.
interface slave_port_if;
  logic swdata;
  logic smode;
  logic mvalid;
  logic srdata;
  logic svalid;
  logic sready;
  logic ssplit;
  logic split_grant;

  modport master (
    output swdata, smode, mvalid, split_grant,
    input  srdata, svalid, sready, ssplit
  );

  modport slave (
    input  swdata, smode, mvalid, split_grant,
    output srdata, svalid, sready, ssplit
  );
endinterface

// File: rtl/serial_shift_out.sv
// Parallel-load LSB-first serialiser; svalid stays high for exactly DATA_WIDTH cycles after a load.
module serial_shift_out #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  srdata,
  output logic                  svalid
);

  localparam int RW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [RW-1:0]         remaining;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg     <= '0;
      remaining <= '0;
    end else if (load) begin
      shreg     <= data;
      remaining <= RW'(DATA_WIDTH);
    end else if (remaining != '0) begin
      shreg     <= shreg >> 1;
      remaining <= remaining - RW'(1);
    end
  end

  assign srdata = shreg[0];
  assign svalid = (remaining != '0);

endmodule

// File: rtl/slave_port.sv
// Bit-serial bus responder: deserialises address/mode/write data, drives a memory port, serialises read data.
// Define SLAVE_PORT_SPLIT_EN to release the bus (ssplit) when memory is slower than SPLIT_WAIT cycles.
module slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SPLIT_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  slave_port_if.slave           bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int CW = cnt_width(ADDR_WIDTH, DATA_WIDTH);

  state_t                state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic                  cnt_inc;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load;

`ifdef SLAVE_PORT_SPLIT_EN
  logic                  have_data;
  logic                  granted;
  logic                  ssplit_q;
  logic [DATA_WIDTH-1:0] rdata_q;
`else
  logic                  unused_split;
  assign unused_split = bus.split_grant ^ (SPLIT_WAIT == 0);
`endif

  // Address bit 0 is taken in IDLE, so in ADDR the counter trails the bit index by one.
  always_comb begin
    state_next = state;
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    cnt_inc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.mvalid) begin
          addr_next[0] = bus.swdata;
          if (ADDR_WIDTH == 1) state_next = bus.smode ? WDATA : MEMR;
          else                 state_next = ADDR;
        end
      end
      ADDR: begin
        if (bus.mvalid) begin
          for (int i = 0; i < ADDR_WIDTH; i++)
            if (i == int'(cnt) + 1) addr_next[i] = bus.swdata;
          cnt_inc = 1'b1;
          if (int'(cnt) == ADDR_WIDTH - 2) state_next = mode ? WDATA : MEMR;
        end
      end
      WDATA: begin
        if (bus.mvalid) begin
          for (int i = 0; i < DATA_WIDTH; i++)
            if (i == int'(cnt)) wdata_next[i] = bus.swdata;
          cnt_inc = 1'b1;
          if (int'(cnt) == DATA_WIDTH - 1) state_next = MEMW;
        end
      end
      MEMW: state_next = IDLE;
      MEMR: begin
        if (mem_rvalid) state_next = RDATA;
`ifdef SLAVE_PORT_SPLIT_EN
        else begin
          cnt_inc = 1'b1;
          if (int'(cnt) == SPLIT_WAIT - 1) state_next = SPLIT;
        end
`endif
      end
`ifdef SLAVE_PORT_SPLIT_EN
      SPLIT: begin
        if ((have_data || mem_rvalid) && (granted || bus.split_grant)) state_next = RDATA;
      end
`endif
      RDATA: begin
        cnt_inc = 1'b1;
        if (int'(cnt) == DATA_WIDTH - 1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    cnt_next = (state_next != state) ? '0 : cnt + CW'(cnt_inc);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      mem_addr  <= addr_next;
      mem_wdata <= wdata_next;
      if (state == IDLE && bus.mvalid) mode <= bus.smode;
    end
  end

`ifdef SLAVE_PORT_SPLIT_EN
  // Data and grant may arrive in either order while split; both are remembered until RDATA.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      have_data <= 1'b0;
      granted   <= 1'b0;
      ssplit_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ssplit_q <= (state == MEMR) && (state_next == SPLIT);
      if (state == SPLIT) begin
        if (mem_rvalid && !have_data) begin
          have_data <= 1'b1;
          rdata_q   <= mem_rdata;
        end
        if (bus.split_grant) granted <= 1'b1;
      end else begin
        have_data <= 1'b0;
        granted   <= 1'b0;
      end
    end
  end

  assign load_data  = have_data ? rdata_q : mem_rdata;
  assign mem_ren    = (state == MEMR) || (state == SPLIT && !have_data);
  assign bus.ssplit = ssplit_q;
`else
  assign load_data  = mem_rdata;
  assign mem_ren    = (state == MEMR);
  assign bus.ssplit = 1'b0;
`endif

  assign load       = (state_next == RDATA) && (state != RDATA);
  assign mem_wen    = (state == MEMW);
  assign bus.sready = (state == IDLE);

  serial_shift_out #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift_out (
    .clk    (clk),
    .rstn   (rstn),
    .load   (load),
    .data   (load_data),
    .srdata (bus.srdata),
    .svalid (bus.svalid)
  );

endmodule

// File: tb/tb_slave_port.sv
// Scoreboard bench for slave_port: write beats and serial read words are queued when driven, checked when they appear.
module tb_slave_port;

  logic        clk;
  logic        rstn;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wen;
  logic        mem_ren;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;

  slave_port_if bus ();

  slave_port dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  logic [7:0]  mem [0:4095];
  int          ren_cycles;
  int          rd_lat;

  int          checks;
  int          failures;
  logic [19:0] wq[$];
  logic [7:0]  rq[$];
  int          bitpos;
  logic [7:0]  rd_word;
  int          wen_count;
  int          ssplit_count;
  logic [1:0]  sready_hist;
  int          drive_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: rvalid follows mem_ren after rd_lat cycles (0 = same cycle).
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    ren_cycles <= mem_ren ? ren_cycles + 1 : 0;
  end
  assign mem_rdata  = mem[mem_addr];
  assign mem_rvalid = mem_ren && (ren_cycles >= rd_lat);

  always @(negedge clk) begin
    if (!rstn) begin
      bitpos = 0;
    end else begin
      if (bus.ssplit) ssplit_count++;
      if (mem_wen) begin
        wen_count++;
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("[TB] FAIL write_beat: got unexpected mem_wen addr=%h data=%h required none", mem_addr, mem_wdata);
        end else begin
          logic [19:0] exp_w;
          exp_w = wq.pop_front();
          if ({mem_addr, mem_wdata} !== exp_w) begin
            failures++;
            $display("[TB] FAIL write_beat: got addr=%h data=%h required addr=%h data=%h",
                     mem_addr, mem_wdata, exp_w[19:8], exp_w[7:0]);
          end
        end
      end
      if (bus.svalid) begin
        rd_word[bitpos] = bus.srdata;
        bitpos++;
        if (bitpos == 8) begin
          bitpos = 0;
          checks++;
          if (rq.size() == 0) begin
            failures++;
            $display("[TB] FAIL read_word: got unexpected word %h required none", rd_word);
          end else begin
            logic [7:0] exp_r;
            exp_r = rq.pop_front();
            if (rd_word !== exp_r) begin
              failures++;
              $display("[TB] FAIL read_word: got %h required %h", rd_word, exp_r);
            end
          end
        end
      end
    end
  end

  task automatic drive_cycle(input logic v, input logic b, input logic m);
    @(posedge clk);
    #1;
    bus.mvalid = v;
    bus.swdata = b;
    bus.smode  = m;
    @(negedge clk);
    if (drive_idx < 2) sready_hist[drive_idx] = bus.sready;
    drive_idx++;
  endtask

  task automatic apply_frame(input logic [11:0] a, input logic wr, input logic [7:0] d, input int gap);
    drive_idx = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0)
        for (int g = 0; g < gap; g++)
          drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drive_cycle(1'b1, a[i], (i == 0) ? wr : 1'($urandom_range(0, 1)));
    end
    if (wr) begin
      for (int i = 0; i < 8; i++) begin
        for (int g = 0; g < gap; g++)
          drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drive_cycle(1'b1, d[i], 1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (wq.size() == 0 && rq.size() == 0) break;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.sready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_sready: got %b required 1", bus.sready);
    end
    checks++;
    if ({bus.svalid, bus.srdata, bus.ssplit, mem_wen, mem_ren} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes: got %b required 00000",
               {bus.svalid, bus.srdata, bus.ssplit, mem_wen, mem_ren});
    end
    checks++;
    if (mem_addr !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_addr: got %h required 000", mem_addr);
    end
    checks++;
    if (mem_wdata !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_wdata: got %h required 00", mem_wdata);
    end
    rstn = 1'b1;
  endtask

  task automatic test_write(input int gap);
    int wen_before;
    wen_before = wen_count;
    wq.push_back({12'h5A3, 8'hC7});
    apply_frame(12'h5A3, 1'b1, 8'hC7, gap);
    checks++;
    if (sready_hist !== 2'b01) begin
      failures++;
      $display("[TB] FAIL write_sready_fall: got first=%b next=%b required 1 then 0",
               sready_hist[0], sready_hist[1]);
    end
    drive_cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (mem_wen !== 1'b1) begin
      failures++;
      $display("[TB] FAIL write_wen_timing: got %b required 1 one cycle after last bit", mem_wen);
    end
    drive_cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if ({mem_wen, bus.sready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL write_done: got wen=%b sready=%b required wen=0 sready=1", mem_wen, bus.sready);
    end
    wait_drain(20);
    checks++;
    if (wq.size() != 0 || wen_count - wen_before != 1) begin
      failures++;
      $display("[TB] FAIL write_pulse_count: got %0d pulses, %0d pending required 1 pulse, 0 pending",
               wen_count - wen_before, wq.size());
      wq.delete();
    end
  endtask

  task automatic test_read();
    int hits;
    rd_lat = 0;
    wq.push_back({12'h0F0, 8'h3C});
    apply_frame(12'h0F0, 1'b1, 8'h3C, 0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    wait_drain(20);
    rq.push_back(8'h3C);
    apply_frame(12'h0F0, 1'b0, 8'h00, 0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if ({mem_ren, bus.svalid, bus.sready} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL read_ren_start: got ren=%b svalid=%b sready=%b required 1 0 0",
               mem_ren, bus.svalid, bus.sready);
    end
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.svalid === 1'b1) hits++;
    end
    checks++;
    if (hits != 8) begin
      failures++;
      $display("[TB] FAIL read_svalid_window: got %0d valid cycles required 8", hits);
    end
    @(negedge clk);
    checks++;
    if ({bus.svalid, bus.sready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL read_done: got svalid=%b sready=%b required 0 1", bus.svalid, bus.sready);
    end
    wait_drain(10);
    checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      failures++;
      $display("[TB] FAIL read_drain: got %0d words pending required 0", rq.size());
      rq.delete();
    end
  endtask

`ifndef SLAVE_PORT_SPLIT_EN
  task automatic test_slow_read();
    int hits;
    int split_before;
    logic ren_ok;
    wq.push_back({12'h2C4, 8'h5E});
    apply_frame(12'h2C4, 1'b1, 8'h5E, 0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    wait_drain(20);
    rd_lat = 9;
    split_before = ssplit_count;
    rq.push_back(8'h5E);
    apply_frame(12'h2C4, 1'b0, 8'h00, 0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    ren_ok = 1'b1;
    hits = 0;
    for (int rel = 1; rel <= 19; rel++) begin
      if (rel > 1) @(negedge clk);
      if (rel <= 10) begin
        ren_ok = ren_ok & mem_ren & ~bus.svalid;
        bus.mvalid = (rel < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.swdata = 1'($urandom_range(0, 1));
      end
      if (rel >= 11 && rel <= 18 && bus.svalid === 1'b1) hits++;
    end
    checks++;
    if (ren_ok !== 1'b1) begin
      failures++;
      $display("[TB] FAIL slow_ren_hold: got ren dropped or early svalid required ren held 10 cycles");
    end
    checks++;
    if (hits != 8) begin
      failures++;
      $display("[TB] FAIL slow_svalid_window: got %0d valid cycles required 8", hits);
    end
    wait_drain(10);
    checks++;
    if (rq.size() != 0 || ssplit_count != split_before) begin
      failures++;
      $display("[TB] FAIL slow_drain: got %0d pending, %0d ssplit pulses required 0 and 0",
               rq.size(), ssplit_count - split_before);
      rq.delete();
    end
    rd_lat = 0;
  endtask
`else
  task automatic test_split();
    int hits;
    int split_before;
    logic ren_ok;
    logic early;
    wq.push_back({12'h2C4, 8'h5E});
    apply_frame(12'h2C4, 1'b1, 8'h5E, 0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    wait_drain(20);
    rd_lat = 9;
    split_before = ssplit_count;
    rq.push_back(8'h5E);
    apply_frame(12'h2C4, 1'b0, 8'h00, 0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    ren_ok = 1'b1;
    early = 1'b0;
    hits = 0;
    for (int rel = 1; rel <= 24; rel++) begin
      if (rel > 1) @(negedge clk);
      if (rel == 5) begin
        checks++;
        if (bus.ssplit !== 1'b1) begin
          failures++;
          $display("[TB] FAIL split_pulse_timing: got %b at MEMR cycle 5 required 1", bus.ssplit);
        end
      end
      if (rel <= 10) ren_ok = ren_ok & mem_ren;
      if (rel <= 15 && bus.svalid === 1'b1) early = 1'b1;
      if (rel >= 16 && rel <= 23 && bus.svalid === 1'b1) hits++;
      if (rel == 15) bus.split_grant = 1'b1;
      if (rel == 16) bus.split_grant = 1'b0;
    end
    checks++;
    if (ren_ok !== 1'b1 || early !== 1'b0) begin
      failures++;
      $display("[TB] FAIL split_hold: got ren_held=%b early_svalid=%b required 1 0", ren_ok, early);
    end
    checks++;
    if (hits != 8) begin
      failures++;
      $display("[TB] FAIL split_svalid_window: got %0d valid cycles from cycle 16 required 8", hits);
    end
    wait_drain(10);
    checks++;
    if (rq.size() != 0 || ssplit_count - split_before != 1) begin
      failures++;
      $display("[TB] FAIL split_drain: got %0d pending, %0d ssplit pulses required 0 and 1",
               rq.size(), ssplit_count - split_before);
      rq.delete();
    end
    rd_lat = 0;
  endtask
`endif

  task automatic test_reset_rdata();
    logic reached;
    wq.push_back({12'h123, 8'h96});
    apply_frame(12'h123, 1'b1, 8'h96, 0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    wait_drain(20);
    rq.push_back(8'h96);
    apply_frame(12'h123, 1'b0, 8'h00, 0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (bitpos == 3) begin
        reached = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (reached !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rdata_progress: got fewer than 3 serial bits required 3 before reset");
    end
    checks++;
    if ({bus.svalid, bus.srdata, bus.sready, mem_ren} !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL rdata_reset: got svalid=%b srdata=%b sready=%b ren=%b required 0 0 1 0",
               bus.svalid, bus.srdata, bus.sready, mem_ren);
    end
    rq.delete();
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;
    rq.push_back(8'h96);
    apply_frame(12'h123, 1'b0, 8'h00, 0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    wait_drain(20);
    checks++;
    if (rq.size() != 0) begin
      failures++;
      $display("[TB] FAIL rdata_after_reset: got %0d words pending required 0", rq.size());
      rq.delete();
    end
  endtask

  task automatic test_back_to_back();
    int wen_before;
    wen_before = wen_count;
    wq.push_back({12'h7FF, 8'hA5});
    rq.push_back(8'hA5);
    apply_frame(12'h7FF, 1'b1, 8'hA5, 0);
    drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    apply_frame(12'h7FF, 1'b0, 8'h00, 0);
    checks++;
    if (sready_hist[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_sready: got %b at read start required 1", sready_hist[0]);
    end
    drive_cycle(1'b0, 1'b0, 1'b0);
    wait_drain(30);
    checks++;
    if (wq.size() != 0 || rq.size() != 0 || wen_count - wen_before != 1) begin
      failures++;
      $display("[TB] FAIL b2b_drain: got %0d writes %0d reads pending, %0d pulses required 0 0 1",
               wq.size(), rq.size(), wen_count - wen_before);
      wq.delete();
      rq.delete();
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    bitpos           = 0;
    wen_count        = 0;
    ssplit_count     = 0;
    drive_idx        = 0;
    sready_hist      = 2'b00;
    rd_lat           = 0;
    ren_cycles       = 0;
    rstn             = 1'b0;
    bus.mvalid       = 1'b0;
    bus.swdata       = 1'b0;
    bus.smode        = 1'b0;
    bus.split_grant  = 1'b0;
    test_reset();
    test_write(0);
    test_write(3);
    test_read();
`ifndef SLAVE_PORT_SPLIT_EN
    test_slow_read();
`else
    test_split();
`endif
    test_reset_rdata();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion required finish within 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
